// File: rtl/fourstate_step_driver.sv
// Drives a four-state pulse-counting Moore machine (codes 1->2->3->4->2...) to a requested code
// with single-cycle step pulses, then checks the fed-back code. Optional macro: FB_RESYNC_EN.
module fourstate_step_driver #(
    parameter int unsigned STEP_GAP = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_code,
    output logic       req_ready,
    output logic       step,
    input  logic [2:0] fb_code,
    output logic       done,
    output logic       resp_err,
    output logic       err,
    output logic [2:0] dbg_state
);

    // Handshake: a request transfers on a posedge where req_valid && req_ready; req_code is
    // sampled only then, and req_ready is high only while idle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PULSE  = 3'd1,
        S_GAP    = 3'd2,
        S_SETTLE = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [3:0] GAP_LEN = 4'(STEP_GAP);

    state_t     state_q, state_d;
    logic [2:0] model_q, model_d;
    logic [2:0] target_q, target_d;
    logic [1:0] pulse_cnt_q, pulse_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       resp_err_q, resp_err_d;
    logic       err_q, err_d;
`ifdef FB_RESYNC_EN
    logic       resync_q, resync_d;
`endif

    // Code 1 is only the power-on state; once left it can never be re-entered.
    function automatic logic reachable(input logic [2:0] m, input logic [2:0] t);
        return (t >= 3'd1) && (t <= 3'd4) && !((t == 3'd1) && (m != 3'd1));
    endfunction

    function automatic logic [1:0] steps_to(input logic [2:0] m, input logic [2:0] t);
        logic [1:0] n;
        if (t == m)          n = 2'd0;
        else if (m == 3'd1)  n = 2'(t - 3'd1);
        else if (t < m)      n = 2'(t - m + 3'd3);
        else                 n = 2'(t - m);
        return n;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            model_q     <= 3'd1;
            target_q    <= 3'd1;
            pulse_cnt_q <= 2'd0;
            gap_cnt_q   <= 4'd0;
            resp_err_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef FB_RESYNC_EN
            resync_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            model_q     <= model_d;
            target_q    <= target_d;
            pulse_cnt_q <= pulse_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            resp_err_q  <= resp_err_d;
            err_q       <= err_d;
`ifdef FB_RESYNC_EN
            resync_q    <= resync_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        model_d     = model_q;
        target_d    = target_q;
        pulse_cnt_d = pulse_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        resp_err_d  = resp_err_q;
        err_d       = err_q;
`ifdef FB_RESYNC_EN
        resync_d    = resync_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    target_d = req_code;
`ifdef FB_RESYNC_EN
                    resync_d = 1'b0;
`endif
                    if (!reachable(model_q, req_code)) begin
                        resp_err_d = 1'b1;
                        err_d      = 1'b1;
                        state_d    = S_DONE;
                    end else if (steps_to(model_q, req_code) == 2'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        pulse_cnt_d = steps_to(model_q, req_code);
                        state_d     = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                model_d     = (model_q == 3'd4) ? 3'd2 : model_q + 3'd1;
                pulse_cnt_d = pulse_cnt_q - 2'd1;
                if (GAP_LEN != 4'd0) begin
                    gap_cnt_d = GAP_LEN - 4'd1;
                    state_d   = S_GAP;
                end else if (pulse_cnt_q != 2'd1) begin
                    state_d = S_PULSE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q != 4'd0) begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end else begin
                    state_d = (pulse_cnt_q != 2'd0) ? S_PULSE : S_SETTLE;
                end
            end
            S_SETTLE: state_d = S_CHECK;
            S_CHECK: begin
                if (fb_code == model_q) begin
                    resp_err_d = 1'b0;
                    state_d    = S_DONE;
                end else begin
                    resp_err_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = S_DONE;
`ifdef FB_RESYNC_EN
                    // One chance per request to trust the machine and re-aim from where it really is.
                    if (!resync_q && fb_code >= 3'd1 && fb_code <= 3'd4) begin
                        resync_d = 1'b1;
                        model_d  = fb_code;
                        if (reachable(fb_code, target_q)) begin
                            resp_err_d  = 1'b0;
                            err_d       = err_q;
                            pulse_cnt_d = steps_to(fb_code, target_q);
                            state_d     = (steps_to(fb_code, target_q) == 2'd0) ? S_CHECK : S_PULSE;
                        end
                    end
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        step      = (state_q == S_PULSE);
        done      = (state_q == S_DONE);
        resp_err  = resp_err_q;
        err       = err_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_fourstate_step_driver.sv
// Bench for fourstate_step_driver: two instances (STEP_GAP=1 and 0) share stimulus, each drives
// its own ideal machine model, and a transaction-level model predicts every output cycle.
module tb_fourstate_step_driver;
  localparam int G0 = 1;
  localparam int G1 = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic [2:0] req_code = 3'd1;
  logic ready0, step0, done0, rerr0, err0, ready1, step1, done1, rerr1, err1;
  logic [2:0] fb0, fb1, dbg0, dbg1, mach0, mach1;
  bit stuck_en = 1'b0;
  logic [2:0] stuck_val = 3'd2;

  int compared = 0;
  int mismatched = 0;
  logic [4:0] exp_q0[$];
  logic [4:0] exp_q1[$];
  int m_exp[2] = '{1, 1};
  logic err_exp[2] = '{1'b0, 1'b0};

  always #5 clock = ~clock;

  fourstate_step_driver #(.STEP_GAP(G0)) dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_code(req_code),
    .req_ready(ready0), .step(step0), .fb_code(fb0), .done(done0),
    .resp_err(rerr0), .err(err0), .dbg_state(dbg0));
  fourstate_step_driver #(.STEP_GAP(G1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_code(req_code),
    .req_ready(ready1), .step(step1), .fb_code(fb1), .done(done1),
    .resp_err(rerr1), .err(err1), .dbg_state(dbg1));

  // Ideal pulse-counting machines, advanced by each DUT's own step output
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mach0 <= 3'd1;
      mach1 <= 3'd1;
    end else begin
      if (step0) mach0 <= (mach0 == 3'd4) ? 3'd2 : mach0 + 3'd1;
      if (step1) mach1 <= (mach1 == 3'd4) ? 3'd2 : mach1 + 3'd1;
    end
  end
  assign fb0 = stuck_en ? stuck_val : mach0;
  assign fb1 = stuck_en ? stuck_val : mach1;

  function automatic bit illegal(input int m, input int t);
    return (t < 1) || (t > 4) || (t == 1 && m != 1);
  endfunction

  function automatic int nsteps(input int m, input int t);
    if (t == m) return 0;
    if (m == 1) return t - 1;
    return (((t - m) % 3) + 3) % 3;
  endfunction

  // Records are {ready, step, done, resp_err, err} for each cycle after the accept edge
  task automatic push_exp(input int i, input int t, output int len);
    logic [4:0] rec[$];
    int m, g, n, fb;
    logic e, r;
    m = m_exp[i];
    g = (i == 0) ? G0 : G1;
    e = err_exp[i];
    r = 1'b1;
    if (illegal(m, t)) begin
      rec.push_back(5'b00111);
      e = 1'b1;
    end else begin
      n = nsteps(m, t);
      for (int a = 0; a < 2; a++) begin
        for (int k = 0; k < n; k++) begin
          rec.push_back({4'b0100, e});
          for (int j = 0; j < g; j++) rec.push_back({4'b0000, e});
        end
        if (n > 0) rec.push_back({4'b0000, e});
        rec.push_back({4'b0000, e});
        m = t;
        fb = stuck_en ? int'(stuck_val) : t;
        if (fb == t) begin
          r = 1'b0;
          break;
        end
`ifdef FB_RESYNC_EN
        if (a == 0 && fb >= 1 && fb <= 4) begin
          m = fb;
          if (illegal(m, t)) break;
          n = nsteps(m, t);
          continue;
        end
`endif
        break;
      end
      rec.push_back({3'b001, r, e | r});
      e = e | r;
    end
    m_exp[i] = m;
    err_exp[i] = e;
    len = rec.size();
    foreach (rec[k]) begin
      if (i == 0) exp_q0.push_back(rec[k]);
      else exp_q1.push_back(rec[k]);
    end
  endtask

  task automatic cmp(input string nm, input logic [4:0] act, input logic [4:0] exp);
    logic [4:0] mask;
    mask = exp[2] ? 5'b11111 : 5'b11101;
    compared++;
    if ((act & mask) !== (exp & mask)) begin
      mismatched++;
      $display("FAIL %s @%0t: ready/step/done/resp_err/err got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic check_lit(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Cycle-by-cycle scoreboard
  always @(negedge clock) begin
    logic [4:0] e0, e1;
    if (reset) begin
      e0 = (exp_q0.size() != 0) ? exp_q0.pop_front() : {4'b1000, err_exp[0]};
      e1 = (exp_q1.size() != 0) ? exp_q1.pop_front() : {4'b1000, err_exp[1]};
      cmp("dut_gap1", {ready0, step0, done0, rerr0, err0}, e0);
      cmp("dut_gap0", {ready1, step1, done1, rerr1, err1}, e1);
    end
  end

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    m_exp = '{1, 1};
    err_exp = '{1'b0, 1'b0};
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic start_req(input logic [2:0] code, output int len);
    int l0, l1;
    @(negedge clock);
    #2;
    push_exp(0, int'(code), l0);
    push_exp(1, int'(code), l1);
    req_valid = 1'b1;
    req_code = code;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_code = 3'($urandom);
    len = (l0 > l1) ? l0 : l1;
  endtask

  task automatic run_req(input logic [2:0] code, output int lat0, output int lat1,
                         output int st0, output int st1);
    int len;
    lat0 = 0; lat1 = 0; st0 = 0; st1 = 0;
    start_req(code, len);
    for (int c = 1; c <= len + 1; c++) begin
      @(negedge clock);
      if (step0) st0++;
      if (step1) st1++;
      if (done0 && lat0 == 0) lat0 = c;
      if (done1 && lat1 == 0) lat1 = c;
    end
  endtask

  task automatic req_pin(input string nm, input logic [2:0] code, input int el0, input int el1,
                         input int es0, input int es1);
    int l0, l1, s0, s1;
    run_req(code, l0, l1, s0, s1);
    check_lit({nm, "_lat_gap1"}, l0, el0);
    check_lit({nm, "_lat_gap0"}, l1, el1);
    check_lit({nm, "_steps_gap1"}, s0, es0);
    check_lit({nm, "_steps_gap0"}, s1, es1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int l0, l1, s0, s1, len, n, found, r;
    logic [2:0] code;
    #3;
    check_lit("reset_ready", int'(ready0 & ready1), 1);
    check_lit("reset_step", int'(step0 | step1), 0);
    check_lit("reset_done_err", int'(done0 | done1 | err0 | err1 | rerr0 | rerr1), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    req_pin("m1_to3", 3'd3, 7, 5, 2, 2);
    req_pin("m3_to4", 3'd4, 5, 4, 1, 1);
    req_pin("m4_to3", 3'd3, 7, 5, 2, 2);
    req_pin("m3_to3", 3'd3, 2, 2, 0, 0);
    req_pin("m3_to2", 3'd2, 7, 5, 2, 2);
    req_pin("m2_to1", 3'd1, 1, 1, 0, 0);
    req_pin("code6", 3'd6, 1, 1, 0, 0);
    check_lit("err_sticky", int'(err0 & err1), 1);
    req_pin("m2_to4_after_err", 3'd4, 7, 5, 2, 2);

    reset_dut();
    req_pin("m1_to4", 3'd4, 9, 6, 3, 3);

    for (int i = 0; i < 30; i++) begin
      r = int'($urandom_range(0, 9));
      code = (r < 8) ? 3'((r % 4) + 1) : 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clock);
      run_req(code, l0, l1, s0, s1);
    end

    reset_dut();
    req_pin("m1_to2", 3'd2, 5, 4, 1, 1);
    stuck_en = 1'b1;
    stuck_val = 3'd2;
    run_req(3'd4, l0, l1, s0, s1);
`ifdef FB_RESYNC_EN
    check_lit("stuck_steps", s0, 4);
`else
    check_lit("stuck_steps", s0, 2);
`endif
    stuck_en = 1'b0;
    reset_dut();

    start_req(3'd4, len);
    n = 0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clock);
      if (step0) begin
        n++;
        if (n == 2) found = 1;
      end
    end
    check_lit("abort_second_pulse_seen", found, 1);
    #1;
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    m_exp = '{1, 1};
    err_exp = '{1'b0, 1'b0};
    #1;
    check_lit("abort_step_low", int'(step0 | step1), 0);
    check_lit("abort_no_done", int'(done0 | done1), 0);
    check_lit("abort_ready", int'(ready0 & ready1), 1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    req_pin("after_abort_m1_to2", 3'd2, 5, 4, 1, 1);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
